// File: rtl/scan_seq_ctrl.sv
// Scan-chain sequencer: LFSR stimulus load/capture/unload with 16-bit MISR compaction of scan-out.
// Define SCAN_SEQ_CMP_EN to add the exp_sig_i/pass_o end-of-run signature compare.
module scan_seq_ctrl #(
    parameter int NREGS  = 1918,
    parameter int SO_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [15:0] npat_i,
    input  logic [15:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] sig_o,
    output logic        scan_tm_o,
    output logic        scan_se_o,
    output logic        scan_si_o,
    input  logic        scan_so_i
`ifdef SCAN_SEQ_CMP_EN
    ,
    input  logic [15:0] exp_sig_i,
    output logic        pass_o
`endif
);
    localparam int CNT_W = $clog2(NREGS + SO_LAT + 1);
    localparam logic [CNT_W-1:0] SHIFT_LEN  = CNT_W'(NREGS);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(NREGS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(NREGS + SO_LAT - 1);
    localparam logic [15:0]      LFSR_INIT  = 16'hACE1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_UNLOAD  = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state;
    logic [15:0]      lfsr;
    logic [15:0]      npat_q;
    logic [15:0]      pat_cnt;
    logic [15:0]      pat_cnt_nxt;
    logic [CNT_W-1:0] shift_cnt;
    logic [CNT_W-1:0] shift_cnt_nxt;
    logic [15:0]      seed_eff;
    logic             cmp_p0;
    logic             cmp_vld;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction

    assign seed_eff      = (seed_i == 16'h0000) ? LFSR_INIT : seed_i;
    assign shift_cnt_nxt = shift_cnt + CNT_W'(1);
    assign pat_cnt_nxt   = pat_cnt + 16'd1;

    // Stage p0: this cycle shifts a bit of interest out of the chain
    assign cmp_p0 = (state == S_UNLOAD) || ((state == S_DRAIN) && (shift_cnt < SHIFT_LEN));

    // Stage p1..pN: delay the flag until the shifted bit shows up on scan_so_i
    generate
        if (SO_LAT == 0) begin : g_lat0
            assign cmp_vld = cmp_p0;
        end else begin : g_lat
            logic [SO_LAT-1:0] cmp_pipe;
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    cmp_pipe <= '0;
                end else begin
                    cmp_pipe[0] <= cmp_p0;
                    for (int i = 1; i < SO_LAT; i++) cmp_pipe[i] <= cmp_pipe[i-1];
                end
            end
            assign cmp_vld = cmp_pipe[SO_LAT-1];
        end
    endgenerate

    // The LFSR register runs one step ahead: it holds the value whose bit 0 is driven next.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= S_IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            scan_tm_o <= 1'b0;
            scan_se_o <= 1'b0;
            scan_si_o <= 1'b0;
            sig_o     <= 16'hFFFF;
            lfsr      <= LFSR_INIT;
            npat_q    <= '0;
            pat_cnt   <= '0;
            shift_cnt <= '0;
        end else begin
            done_o <= 1'b0;
            if (cmp_vld) sig_o <= misr_step(sig_o, scan_so_i);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        npat_q    <= npat_i;
                        pat_cnt   <= '0;
                        shift_cnt <= '0;
                        sig_o     <= 16'hFFFF;
                        busy_o    <= 1'b1;
                        scan_tm_o <= 1'b1;
                        if (npat_i == 16'd0) begin
                            state <= S_DONE;
                            lfsr  <= seed_eff;
                        end else begin
                            state     <= S_LOAD;
                            scan_se_o <= 1'b1;
                            scan_si_o <= seed_eff[0];
                            lfsr      <= lfsr_step(seed_eff);
                        end
                    end
                end
                S_LOAD, S_UNLOAD: begin
                    if (shift_cnt == SHIFT_LAST) begin
                        state     <= S_CAPTURE;
                        scan_se_o <= 1'b0;
                        scan_si_o <= 1'b0;
                        shift_cnt <= '0;
                    end else begin
                        shift_cnt <= shift_cnt_nxt;
                        scan_si_o <= lfsr[0];
                        lfsr      <= lfsr_step(lfsr);
                    end
                end
                S_CAPTURE: begin
                    pat_cnt   <= pat_cnt_nxt;
                    scan_se_o <= 1'b1;
                    shift_cnt <= '0;
                    if (pat_cnt_nxt == npat_q) begin
                        state     <= S_DRAIN;
                        scan_si_o <= 1'b0;
                    end else begin
                        state     <= S_UNLOAD;
                        scan_si_o <= lfsr[0];
                        lfsr      <= lfsr_step(lfsr);
                    end
                end
                S_DRAIN: begin
                    scan_si_o <= 1'b0;
                    if (shift_cnt == DRAIN_LAST) begin
                        state     <= S_DONE;
                        scan_se_o <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt_nxt;
                        scan_se_o <= (shift_cnt_nxt < SHIFT_LEN);
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy_o    <= 1'b0;
                    scan_tm_o <= 1'b0;
                    scan_se_o <= 1'b0;
                    done_o    <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCAN_SEQ_CMP_EN
    // Signature is final by the DONE cycle; the verdict is published with done_o.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pass_o <= 1'b0;
        end else if ((state == S_IDLE) && start_i) begin
            pass_o <= 1'b0;
        end else if (state == S_DONE) begin
            pass_o <= (sig_o == exp_sig_i);
        end
    end
`endif

endmodule
